reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the single write port of the 16-bit register bank between several requesters (writeback, load unit, debug/host port, interrupt save). Each cycle it selects one pending request by round-robin, or by a held lock, and acknowledges it in the same cycle. It then drives a registered write strobe, address and data into the register bank one cycle later. It sits between the datapath sources and the bank of `register` instances, so the bank sees at most one write per clock.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 16: register data width.
- `ADDR_WIDTH`, default 4: register address width.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `req`, in, `NUM_REQ`: request i pending.
- `req_lock`, in, `NUM_REQ`: requester i asks to keep ownership after its current grant.
- `req_addr`, in, `NUM_REQ*ADDR_WIDTH`: flattened; slice i is `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_data`, in, `NUM_REQ*DATA_WIDTH`: flattened, same slicing.
- `ack`, out, `NUM_REQ`: combinational one-hot; request i accepted at this rising edge.
- `wr_en`, out, 1: registered write strobe to the register bank.
- `wr_addr`, out, `ADDR_WIDTH`: registered write address.
- `wr_data`, out, `DATA_WIDTH`: registered write data.
- `owner`, out, `$clog2(NUM_REQ)`: index of the last granted requester.
- `locked`, out, 1: FSM is in LOCKED.

## Operation
FSM states:
- ARB: round-robin among `req`. Search starts at `owner+1` and wraps modulo `NUM_REQ`.
- LOCKED: only requester `owner` can be acked.

Transitions:
- ARB -> LOCKED when the acked requester has `req_lock` high.
- LOCKED -> ARB at the first edge where `req[owner]` or `req_lock[owner]` is low.
  - If `req[owner]` is low on that edge, no ack is issued that cycle; arbitration resumes next cycle.
  - If `req[owner]` is high and `req_lock[owner]` is low, that final request is acked.

Ack and write rules:
- `ack` is at most one-hot. It is 0 when no eligible request exists, or in LOCKED when `req[owner]` is low.
- On an edge with `ack[i]`=1: `wr_en`<=1, `wr_addr`<=slice i of `req_addr`, `wr_data`<=slice i of `req_data`, `owner`<=i.
- On an edge with no ack: `wr_en`<=0. `wr_addr`, `wr_data` and `owner` hold.
- Requester handshake: a requester holds `req` and its addr/data stable until it sees `ack[i]` at a rising edge. It then either drops `req` or presents its next write. Requests are never dropped or duplicated.
- Requests arriving while another requester is locked wait; there is no timeout.

Reset values:
- `wr_en`=0, `wr_addr`=0, `wr_data`=0.
- `owner`=`NUM_REQ-1`, so requester 0 has first priority after reset.
- FSM state ARB, `locked`=0.
- `ack` is forced to 0 while `reset`=1.

## Timing
- Ack latency is 0: combinational from `req`, `req_lock`, the FSM state and `owner`.
- Write latency is 1: `wr_en`/`wr_addr`/`wr_data` are valid in the cycle after the acking edge. The register bank captures them on the following edge.
- Throughput is one write per cycle, including back-to-back writes by different requesters.
- Under continuous requests from all requesters, each requester is acked within `NUM_REQ` cycles, unless one requester holds the lock.
- Asynchronous reset asserted mid-lock or mid-write clears state at once. A write registered before reset is discarded; there is no partial output.
- `req` with all zeros in ARB is an idle cycle. `owner` is unchanged, so the round-robin position is preserved.

## Structure
- Shared package holds the FSM state encoding (`ARB`=1'b0, `LOCKED`=1'b1) and the default width constants (16, 4).
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs are the request vector and the last index; outputs are the one-hot winner and its index.
- The top level holds the FSM, the output registers and the data mux.

## Test plan
- **Reset:** assert `reset` mid-cycle with `req`=4'b1111 -> `ack`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `owner`=3 immediately, without waiting for `CLK`.
- **Round-robin:** `req`=4'b1111 held for 5 cycles -> acks in order 0,1,2,3,0. Next-cycle writes carry each requester's addr/data, e.g. r2 addr 4'h5 data 16'h8888 -> `wr_addr`=5, `wr_data`=16'h8888.
- **Sparse request:** only r3 requests (addr 4'hA, data 16'hBEEF) -> `ack`=4'b1000 in the same cycle. Next cycle `wr_en`=1, `wr_addr`=A, `wr_data`=16'hBEEF. The cycle after, `wr_en`=0.
- **Lock:** r1 requests with `req_lock`=1 for 3 cycles while r0 and r2 also request -> r1 acked 3 times in a row with `locked`=1. When r1 drops the lock, r2 is acked next, then r0.
- **Lock release by dropping req:** in LOCKED, r1 drops `req` -> `ack`=0 and `wr_en`=0 next cycle, `locked`=0. Arbitration resumes the cycle after.
- **Reset mid-lock:** while r1 is locked and writing 16'h1234, assert `reset` -> `locked`=0 and `wr_en`=0 immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared FSM encoding and default widths for the register write arbiter
package reg_write_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 4;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, search starts just after the last winner
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Walk last+1 .. last+N modulo N and keep the first pending request
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            if (grant == '0 && req[(int'(last) + i) % N]) begin
                grant[(int'(last) + i) % N] = 1'b1;
                idx                         = IW'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin/lockable arbiter for the single register bank write port
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int IW         = $clog2(NUM_REQ)
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             wr_en,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic [IW-1:0]                    owner,
    output logic                             locked
);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           owner_q, owner_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [NUM_REQ-1:0]      pick_grant, grant;
    logic [IW-1:0]           pick_idx, grant_idx;
    logic                    grant_any;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .req   (req),
        .last  (owner_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Choose the winner, next FSM state and next write-port contents
    always_comb begin
        state_d   = state_q;
        grant     = '0;
        grant_idx = owner_q;
        if (state_q == ARB) begin
            grant     = pick_grant;
            grant_idx = pick_idx;
            if (|pick_grant && req_lock[pick_idx])
                state_d = LOCKED;
        end else begin
            grant = req[owner_q] ? (NUM_REQ'(1) << owner_q) : '0;
            if (!req[owner_q] || !req_lock[owner_q])
                state_d = ARB;
        end
        grant_any = |grant;
        wr_en_d   = grant_any;
        owner_d   = grant_any ? grant_idx : owner_q;
        wr_addr_d = grant_any ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : wr_addr_q;
        wr_data_d = grant_any ? req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH] : wr_data_q;
    end

    // State and write-port registers; owner resets to the last index so requester 0 goes first
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ARB;
            owner_q   <= IW'(NUM_REQ - 1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ack     = reset ? '0 : grant;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign owner   = owner_q;
    assign locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed-vector bench for the register write arbiter
module tb_reg_write_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic [3:0]  req, req_lock, ack;
    logic [3:0]  a [4];
    logic [15:0] d [4];
    logic [15:0] req_addr;
    logic [63:0] req_data;
    logic        wr_en, locked;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  owner;
    int          tests_run = 0;
    int          tests_failed = 0;

    assign req_addr = {a[3], a[2], a[1], a[0]};
    assign req_data = {d[3], d[2], d[1], d[0]};

    always #5 CLK = ~CLK;

    reg_write_arbiter dut (
        .CLK      (CLK),
        .reset    (reset),
        .req      (req),
        .req_lock (req_lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .owner    (owner),
        .locked   (locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        a[0] = 4'h1; d[0] = 16'h1111;
        a[1] = 4'h3; d[1] = 16'h2222;
        a[2] = 4'h5; d[2] = 16'h8888;
        a[3] = 4'hA; d[3] = 16'hBEEF;
        reset = 1'b1; req = '0; req_lock = '0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        check("rst_owner", 32'(owner), 32'd3);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("rr_ack%0d", k), 32'(ack), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("rr_wr_en%0d", k), 32'(wr_en), 32'd1);
            check($sformatf("rr_addr%0d", k), 32'(wr_addr), 32'(a[k % 4]));
            check($sformatf("rr_data%0d", k), 32'(wr_data), 32'(d[k % 4]));
            check($sformatf("rr_owner%0d", k), 32'(owner), 32'(k % 4));
        end

        req = '0;
        #1 check("idle_ack", 32'(ack), 32'd0);
        tick();
        check("idle_wr_en", 32'(wr_en), 32'd0);
        check("idle_owner", 32'(owner), 32'd0);

        req = 4'b1000;
        #1 check("sparse_ack", 32'(ack), 32'b1000);
        tick();
        req = '0;
        check("sparse_wr_en", 32'(wr_en), 32'd1);
        check("sparse_addr", 32'(wr_addr), 32'hA);
        check("sparse_data", 32'(wr_data), 32'hBEEF);
        tick();
        check("sparse_wr_en_off", 32'(wr_en), 32'd0);

        req = 4'b1111;
        tick();
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_addr", 32'(wr_addr), 32'd0);
        check("arst_data", 32'(wr_data), 32'd0);
        check("arst_owner", 32'(owner), 32'd3);
        tick();
        reset = 1'b0;

        tick();
        check("lk_pre_owner", 32'(owner), 32'd0);
        req = 4'b0111; req_lock = 4'b0010; d[1] = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("lk_ack%0d", c), 32'(ack), 32'b0010);
            tick();
            check($sformatf("lk_locked%0d", c), 32'(locked), 32'd1);
            check($sformatf("lk_data%0d", c), 32'(wr_data), 32'h1234);
        end
        req_lock = '0;
        #1 check("lk_final_ack", 32'(ack), 32'b0010);
        tick();
        check("lk_unlocked", 32'(locked), 32'd0);
        req = 4'b0101;
        #1 check("lk_next_r2", 32'(ack), 32'b0100);
        tick();
        #1 check("lk_next_r0", 32'(ack), 32'b0001);
        tick();
        check("lk_owner_r0", 32'(owner), 32'd0);

        req = 4'b0010; req_lock = 4'b0010;
        #1 check("drop_ack1", 32'(ack), 32'b0010);
        tick();
        check("drop_locked", 32'(locked), 32'd1);
        req = '0;
        #1 check("drop_ack0", 32'(ack), 32'd0);
        tick();
        check("drop_wr_en", 32'(wr_en), 32'd0);
        check("drop_unlocked", 32'(locked), 32'd0);
        check("drop_owner", 32'(owner), 32'd1);
        req = 4'b0001; req_lock = '0;
        #1 check("drop_resume", 32'(ack), 32'b0001);
        tick();
        check("drop_resume_wr", 32'(wr_en), 32'd1);

        req = 4'b0010; req_lock = 4'b0010;
        #1 check("ml_ack", 32'(ack), 32'b0010);
        tick();
        check("ml_locked", 32'(locked), 32'd1);
        check("ml_data", 32'(wr_data), 32'h1234);
        #2 reset = 1'b1;
        #1;
        check("ml_rst_locked", 32'(locked), 32'd0);
        check("ml_rst_wr_en", 32'(wr_en), 32'd0);
        check("ml_rst_data", 32'(wr_data), 32'd0);
        check("ml_rst_ack", 32'(ack), 32'd0);
        tick();
        reset = 1'b0; req = 4'b0011; req_lock = '0;
        #1 check("ml_first_r0", 32'(ack), 32'b0001);
        tick();
        check("ml_owner", 32'(owner), 32'd0);
        check("ml_addr", 32'(wr_addr), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
